timer_count_core: RTL
=====================

Name: timer_count_core

Overview:
- Counting engine of the 8-bit timer IP, directly downstream of the APB register file (TDR/TCR/TSR).
- Takes the decoded TCR control fields and the TDR reload value, generates the internal clk_in tick from pclk via a selectable prescaler, and runs the 8-bit up/down counter.
- Produces the sticky overflow/underflow flags that the register file presents as TSR[0]/TSR[1].

Parameters:
- CNT_W, 8, counter and TDR width
- DIV_W, 4, prescaler counter width; must be at least 4 so the /16 tap exists

Ports:
- pclk  in  1  system clock
- preset  in  1  reset, synchronous, active-high
- tdr  in  CNT_W  reload value from TDR
- load  in  1  TCR[7]; level, loads tdr into counter
- up_dn  in  1  TCR[5]; 0 = count up, 1 = count down
- en  in  1  TCR[4]; count enable (0 = pause)
- cks  in  2  TCR[1:0]; clk_in select: 00 = pclk/2, 01 = /4, 10 = /8, 11 = /16
- clr_ovf  in  1  one-pclk pulse from TSR write with bit0 = 0
- clr_udf  in  1  one-pclk pulse from TSR write with bit1 = 0
- tcnt  out  CNT_W  current counter value
- ovf  out  1  sticky overflow flag
- udf  out  1  sticky underflow flag
- tick  out  1  one-pclk clk_in strobe (debug/observability)

Behaviour:
- Reset (preset = 1 at a pclk edge): div_cnt, tcnt, ovf, udf, tick, sel_q and cks_q all go to 0. Reset mid-count aborts immediately, and no flag is set on that edge.
- Prescaler:
  - div_cnt is free-running, increments every pclk and wraps; it is never reset by load, en or cks.
  - sel = div_cnt[cks]; sel_q is sel registered.
  - tick is registered: tick = 1 in the cycle after sel rises (sel & ~sel_q).
  - Resulting period is 2/4/8/16 pclk.
  - cks_q registers cks. In a cycle where cks != cks_q, the rising-edge detect is suppressed, so a cks change produces no glitch tick.
- Counter update priority, per pclk (evaluated every pclk, not gated by tick for load):
  1. load = 1: tcnt <= tdr. No flag change; tick ignored.
  2. en = 1 and tick = 1 and up_dn = 0: tcnt <= tcnt + 1, modulo 2^CNT_W.
     - If tcnt == all-ones, the result wraps to 0 and ovf is set the same edge.
  3. en = 1 and tick = 1 and up_dn = 1: tcnt <= tcnt - 1.
     - If tcnt == 0, the result wraps to all-ones and udf is set the same edge.
  4. Otherwise tcnt holds. en = 0 is pause; resuming continues from the held value.
- Latencies:
  - load → tcnt = tdr: 1 pclk.
  - Tick → tcnt change: 1 pclk.
  - First count after en rises: within one prescaler period. The bench allows ±1 period.
- Flags:
  - Sticky until cleared by the corresponding clr pulse; cleared the next edge.
  - Set and clear in the same cycle: set wins.
  - up_dn changes take effect on the next tick; there is no re-load.
- Load held high continuously: the counter stays at tdr and never overflows.

Test Plan:
- Reset mid-count: preset pulsed at tcnt = 0x37 → next edge tcnt = 0, ovf = udf = tick = 0.
- Overflow: tdr = 0x00, load pulse, then en = 1, up_dn = 0, cks = 00 → ovf rises 512 ± 2 pclk after en, tcnt = 0x00 at that edge; clr_ovf pulse → ovf = 0 the next cycle.
- Underflow: tdr = 0x02, load, en = 1, up_dn = 1, cks = 01 → udf rises after the 3rd tick (12 ± 4 pclk), tcnt = 0xFF; tick period measured as 4 pclk.
- Pause/resume:
  - up count at cks = 00; drop en when tcnt = 0x40 for 50 pclk → tcnt stays 0x40 throughout.
  - Re-enable → reaches 0x41 within 2 pclk, and ovf arrives after (0x100 − 0x40) × 2 pclk more.
- Priority and collisions:
  - load = 1 coincident with a tick at tcnt = 0xFF (up) → tcnt = tdr, ovf stays 0.
  - clr_ovf coincident with a new overflow → ovf stays 1.
- cks switch 00 → 11 mid-count → no tick in the switch cycle; subsequent tick spacing is exactly 16 pclk.

Source files
------------

// File: rtl/timer_count_core.sv
// timer_count_core: prescaled 8-bit up/down counting engine
// with sticky overflow/underflow flags for the timer IP.
module timer_count_core #(
  parameter int CNT_W = 8,
  parameter int DIV_W = 4
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic [CNT_W-1:0] tdr,
  input  logic             load,
  input  logic             up_dn,
  input  logic             en,
  input  logic [1:0]       cks,
  input  logic             clr_ovf,
  input  logic             clr_udf,
  output logic [CNT_W-1:0] tcnt,
  output logic             ovf,
  output logic             udf,
  output logic             tick
);

  logic [DIV_W-1:0] div_cnt;
  logic             sel;
  logic             sel_q;
  logic [1:0]       cks_q;
  logic             rise;

  logic             step;
  logic [CNT_W-1:0] cnt_nxt;
  logic             set_ovf;
  logic             set_udf;

  // Tap select; a tap change masks the edge detect
  // so the old/new tap mix cannot fake a rising edge.
  assign sel  = div_cnt[cks];
  assign rise = sel & ~sel_q & (cks == cks_q);

  // Free-running divider and registered clk_in strobe.
  always_ff @(posedge pclk) begin
    if (preset) begin
      div_cnt <= '0;
      sel_q   <= 1'b0;
      cks_q   <= 2'b00;
      tick    <= 1'b0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      sel_q   <= sel;
      cks_q   <= cks;
      tick    <= rise;
    end
  end

  // Load beats counting; counting only on an enabled tick.
  assign step = en & tick & ~load;

  // Next count value and wrap detection.
  always_comb begin
    cnt_nxt = tcnt;
    set_ovf = 1'b0;
    set_udf = 1'b0;
    unique case (1'b1)
      load: begin
        cnt_nxt = tdr;
      end
      step & ~up_dn: begin
        cnt_nxt = tcnt + CNT_W'(1);
        set_ovf = &tcnt;
      end
      step & up_dn: begin
        cnt_nxt = tcnt - CNT_W'(1);
        set_udf = ~|tcnt;
      end
      default: begin
        cnt_nxt = tcnt;
      end
    endcase
  end

  // Counter and sticky flags; a new event wins over a clear.
  always_ff @(posedge pclk) begin
    if (preset) begin
      tcnt <= '0;
      ovf  <= 1'b0;
      udf  <= 1'b0;
    end else begin
      tcnt <= cnt_nxt;
      ovf  <= set_ovf | (ovf & ~clr_ovf);
      udf  <= set_udf | (udf & ~clr_udf);
    end
  end

endmodule
